// File: rtl/alu_bcd_display_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Package : alu_bcd_display_pkg                                      |
// | Purpose : Shared types and constants for the add/subtract unit     |
// |           with the BCD seven-segment display path.                 |
// |           Contents: FSM state enum, active-low segment codes,      |
// |           shift-counter width helper.                              |
// | Rev     : 1.0  initial release                                     |
// +--------------------------------------------------------------------+
package alu_bcd_display_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CONVERT = 2'd1,
      FINISH  = 2'd2
   } state_t;

   // Active-low {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_MINUS = 7'b0111111;
   localparam logic [6:0] SEG_ZERO  = 7'b1000000;

   // Counter must reach WIDTH (index of the last of WIDTH+1 shifts).
   function automatic int cnt_width(input int width);
      return $clog2(width + 2);
   endfunction

endpackage
`default_nettype wire

// File: rtl/alu_bcd_display_bcd_seg_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : bcd_seg_decoder                                          |
// | Purpose : Combinational 4-bit BCD to active-low 7-segment decoder. |
// | Ports   : bcd   in  4  BCD digit (0-9)                             |
// |           blank in  1  force all segments off                      |
// |           seg   out 7  {g,f,e,d,c,b,a}, active-low                 |
// | Rev     : 1.0  initial release                                     |
// +--------------------------------------------------------------------+
module bcd_seg_decoder
   import alu_bcd_display_pkg::*;
(
   input  logic [3:0] bcd,
   input  logic       blank,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      if (!blank) begin
         case (bcd)
            4'd0:    seg = SEG_ZERO;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = SEG_BLANK;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/alu_bcd_display.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : alu_bcd_display                                          |
// | Purpose : Signed add/subtract with start/busy/done handshake; the  |
// |           result is converted to sign-magnitude decimal by a       |
// |           one-shift-per-clock double-dabble engine and shown on    |
// |           DIGITS seven-segment displays plus a sign display.       |
// | Ports   : clk, reset (async, active-high)                          |
// |           start, op (0=add,1=sub), left/right [WIDTH-1:0]          |
// |           busy, done, result [WIDTH:0]                             |
// |           seg [7*DIGITS-1:0], sign_seg [6:0]  (active-low)         |
// | Rev     : 1.0  initial release                                     |
// +--------------------------------------------------------------------+
module alu_bcd_display
   import alu_bcd_display_pkg::*;
#(
   parameter int WIDTH    = 5,
   parameter int DIGITS   = 2,
   parameter int BLANK_LZ = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  op,
   input  logic [WIDTH-1:0]      left,
   input  logic [WIDTH-1:0]      right,
   output logic                  busy,
   output logic                  done,
   output logic [WIDTH:0]        result,
   output logic [7*DIGITS-1:0]   seg,
   output logic [6:0]            sign_seg
);

   localparam int CW = cnt_width(WIDTH);
   localparam int BW = 4 * DIGITS;

   state_t              r_state;
   logic [CW-1:0]       r_cnt;
   logic [BW-1:0]       r_bcd;
   logic [WIDTH:0]      r_mag;
   logic                r_neg;

   logic [WIDTH:0]      w_sum;
   logic [WIDTH:0]      w_mag;
   logic [BW-1:0]       w_adj;
   logic [DIGITS-1:0]   w_blank;
   logic [7*DIGITS-1:0] w_seg;
   logic                w_zero_hi;

   // Sign-extend to WIDTH+1 so the sum can never overflow.
   assign w_sum = op ? ({left[WIDTH-1], left} - {right[WIDTH-1], right})
                     : ({left[WIDTH-1], left} + {right[WIDTH-1], right});

   // -(-2^WIDTH) wraps to 2^WIDTH, which is still correct as unsigned.
   assign w_mag = w_sum[WIDTH] ? -w_sum : w_sum;

   // Double-dabble correction applied before each shift.
   always_comb begin
      w_adj = r_bcd;
      for (int i = 0; i < DIGITS; i++) begin
         if (r_bcd[4*i +: 4] >= 4'd5) begin
            w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
         end
      end
   end

   // A digit is blanked only when it and every higher digit are zero;
   // digit 0 always shows.
   always_comb begin
      w_zero_hi = 1'b1;
      w_blank   = '0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         w_zero_hi = w_zero_hi && (r_bcd[4*i +: 4] == 4'd0);
         if (i > 0 && BLANK_LZ != 0) begin
            w_blank[i] = w_zero_hi;
         end
      end
   end

   generate
      for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
         bcd_seg_decoder u_dec (
            .bcd   (r_bcd[4*gi +: 4]),
            .blank (w_blank[gi]),
            .seg   (w_seg[7*gi +: 7])
         );
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_bcd    <= '0;
         r_mag    <= '0;
         r_neg    <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         result   <= '0;
         seg      <= {DIGITS{SEG_ZERO}};
         sign_seg <= SEG_BLANK;
      end else begin
         done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  result  <= w_sum;
                  r_mag   <= w_mag;
                  r_neg   <= w_sum[WIDTH];
                  r_bcd   <= '0;
                  r_cnt   <= '0;
                  busy    <= 1'b1;
                  r_state <= CONVERT;
               end
            end
            CONVERT: begin
               {r_bcd, r_mag} <= {w_adj, r_mag} << 1;
               if (r_cnt == CW'(WIDTH)) begin
                  r_state <= FINISH;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            FINISH: begin
               seg      <= w_seg;
               sign_seg <= r_neg ? SEG_MINUS : SEG_BLANK;
               done     <= 1'b1;
               busy     <= 1'b0;
               r_state  <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_alu_bcd_display.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : tb_alu_bcd_display                                       |
// | Purpose : Self-checking bench for alu_bcd_display. Expected        |
// |           results are queued when an operation is launched and    |
// |           compared when done pulses. A second instance with        |
// |           leading-zero blanking disabled shares the stimulus.      |
// | Rev     : 1.0  initial release                                     |
// +--------------------------------------------------------------------+
module tb_alu_bcd_display;

   localparam int WIDTH  = 5;
   localparam int DIGITS = 2;

   typedef struct {
      logic [WIDTH:0]        res;
      logic [7*DIGITS-1:0]   seg;
      logic [6:0]            sgn;
      int                    e0;
   } exp_t;

   logic                clk = 1'b0;
   logic                reset;
   logic                start;
   logic                op;
   logic [WIDTH-1:0]    left;
   logic [WIDTH-1:0]    right;
   logic                busy, done;
   logic [WIDTH:0]      result;
   logic [7*DIGITS-1:0] seg;
   logic [6:0]          sign_seg;
   logic                busy_nb, done_nb;
   logic [WIDTH:0]      result_nb;
   logic [7*DIGITS-1:0] seg_nb;
   logic [6:0]          sign_seg_nb;

   int   n_vec = 0;
   int   n_err = 0;
   int   edge_cnt = 0;
   exp_t sb[$];

   alu_bcd_display #(.WIDTH(WIDTH), .DIGITS(DIGITS), .BLANK_LZ(1)) u_dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .left(left), .right(right),
      .busy(busy), .done(done), .result(result), .seg(seg), .sign_seg(sign_seg)
   );

   alu_bcd_display #(.WIDTH(WIDTH), .DIGITS(DIGITS), .BLANK_LZ(0)) u_dut_nb (
      .clk(clk), .reset(reset), .start(start), .op(op), .left(left), .right(right),
      .busy(busy_nb), .done(done_nb), .result(result_nb), .seg(seg_nb), .sign_seg(sign_seg_nb)
   );

   always #5 clk = ~clk;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [6:0] seg_of(input int d);
      case (d)
         0: return 7'b1000000;
         1: return 7'b1111001;
         2: return 7'b0100100;
         3: return 7'b0110000;
         4: return 7'b0011001;
         5: return 7'b0010010;
         6: return 7'b0000010;
         7: return 7'b1111000;
         8: return 7'b0000000;
         9: return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   // Model for the blanking instance; the expected value is pushed with
   // the edge index at which start will be sampled.
   task automatic drive(input logic o, input int a, input int b);
      exp_t e;
      int   r, m, tens, ones;
      start = 1'b1; op = o; left = a[WIDTH-1:0]; right = b[WIDTH-1:0];
      r     = o ? (a - b) : (a + b);
      m     = (r < 0) ? -r : r;
      tens  = m / 10;
      ones  = m % 10;
      e.res = r[WIDTH:0];
      e.seg = {(tens == 0) ? 7'b1111111 : seg_of(tens), seg_of(ones)};
      e.sgn = (r < 0) ? 7'b0111111 : 7'b1111111;
      e.e0  = edge_cnt + 1;
      sb.push_back(e);
   endtask

   task automatic start_op(input logic o, input int a, input int b);
      @(negedge clk);
      drive(o, a, b);
      @(negedge clk);
      start = 1'b0;
   endtask

   // Returns at the negedge where done is high.
   task automatic wait_done();
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (done) return;
      end
      chk("done_timeout", 32'd0, 32'd1);
   endtask

   always @(posedge clk) begin
      #1;
      if (done) begin
         if (sb.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("result",   32'(result),   32'(e.res));
            chk("seg",      32'(seg),      32'(e.seg));
            chk("sign_seg", 32'(sign_seg), 32'(e.sgn));
            chk("latency",  32'(edge_cnt), 32'(e.e0 + 7));
         end
      end
   end

   initial begin
      int busy_ok;
      int seen;
      reset = 1'b1; start = 1'b0; op = 1'b0; left = '0; right = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy",   32'(busy),     32'd0);
      chk("rst_done",   32'(done),     32'd0);
      chk("rst_result", 32'(result),   32'd0);
      chk("rst_seg",    32'(seg),      32'h2040);
      chk("rst_sign",   32'(sign_seg), 32'h7f);
      @(negedge clk);
      reset = 1'b0;

      // 7 + 5 with busy tracking through the conversion.
      start_op(1'b0, 7, 5);
      busy_ok = 1;
      for (int k = 0; k < 6; k++) begin
         if (busy !== 1'b1) busy_ok = 0;
         @(negedge clk);
      end
      chk("busy_during_op", 32'(busy_ok), 32'd1);
      if (!done) wait_done();
      chk("busy_in_done_cycle", 32'(busy), 32'd0);

      start_op(1'b1, 3, 10);
      chk("result_early", 32'(result), 32'h39);
      wait_done();
      start_op(1'b0, -16, -16);
      wait_done();
      start_op(1'b1, 15, -16);
      wait_done();

      // Start during CONVERT is ignored.
      start_op(1'b0, 9, -4);
      @(negedge clk);
      start = 1'b1; op = 1'b1; left = 5'b11000; right = 5'd7;
      @(negedge clk);
      start = 1'b0;
      wait_done();

      // Back-to-back: start in the done cycle.
      drive(1'b0, -3, -9);
      @(negedge clk);
      start = 1'b0;
      wait_done();

      // 0 + 4 on both instances: blanking vs. no blanking.
      start_op(1'b0, 0, 4);
      wait_done();
      chk("nb_seg",  32'(seg_nb), {18'd0, seg_of(0), seg_of(4)});
      chk("nb_done", 32'(done_nb), 32'd1);

      // Asynchronous reset during CONVERT; nothing queued.
      @(negedge clk);
      start = 1'b1; op = 1'b0; left = 5'd6; right = 5'd7;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      chk("arst_busy",   32'(busy),     32'd0);
      chk("arst_done",   32'(done),     32'd0);
      chk("arst_result", 32'(result),   32'd0);
      chk("arst_seg",    32'(seg),      32'h2040);
      chk("arst_sign",   32'(sign_seg), 32'h7f);
      @(negedge clk);
      reset = 1'b0;
      seen = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (done) seen = 1;
      end
      chk("no_done_after_reset", 32'(seen), 32'd0);
      chk("sb_empty", 32'(sb.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
